dmem_port_arbiter: RTL

//  Shares the single data-memory port (m_data_*) between the pipeline M stage (CPU) and a

---
 rtl/dmem_port_arbiter_pkg.sv | 20 ++
 rtl/dmem_port_arbiter_age_counter.sv | 43 ++++
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding,
// byte-enable constants and the counter width used for aging and burst length.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_DMA   = 2'd1,
        S_YIELD = 2'd2
    } arb_state_e;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

    // Wide enough for MAX_WAIT up to 255 and BURST_MAX up to 15.
    localparam int CNT_W = 8;

    function automatic logic is_read(input logic [3:0] byteen);
        return byteen == BYTEEN_NONE;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_age_counter.sv
// Saturating up-counter with synchronous clear; shared by the DMA aging
// counter (wait_cnt) and the burst beat counter (beat_cnt).
module arb_age_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int W   = CNT_W,
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o,
    output logic last_o
);

    localparam logic [W-1:0] MAX_C  = W'(MAX);
    localparam logic [W-1:0] LAST_C = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o  = (cnt_q == MAX_C);
    assign last_o = (cnt_q == LAST_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the M stage (priority) and a DMA/debug master,
// with aging-forced DMA bursts of bounded length.
//
//  state   | meaning
//  S_CPU   | CPU owns the port; DMA only gets idle slots, aging counts stalled DMA cycles
//  S_DMA   | DMA burst in progress; CPU requests are stalled
//  S_YIELD | one CPU-priority cycle after a burst, aging disabled
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic        stall_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic        in_dma;
    logic        stall_raw;
    logic        wr_block;
    logic        gnt_raw;
    logic        gnt_read;
    logic        to_dma;
    logic        burst_done;

    logic        wait_clr;
    logic        wait_inc;
    logic        wait_sat;
    logic        wait_last;
    logic        beat_clr;
    logic        beat_inc;
    logic        beat_sat;
    logic        beat_last;

    assign in_dma    = (state_q == S_DMA);
    assign stall_raw = in_dma && cpu_req;

    // A write beat must not land in the same cycle the CPU is being released.
    assign wr_block  = !is_read(dma_byteen) && stall_q && !stall_raw;
    assign gnt_raw   = dma_req && !wr_block && (in_dma || !cpu_req);
    assign gnt_read  = gnt_raw && is_read(dma_byteen);

    assign wait_inc   = (state_q == S_CPU) && cpu_req && dma_req;
    assign to_dma     = wait_inc && (wait_last || wait_sat);
    assign wait_clr   = !wait_inc || to_dma;

    assign beat_inc   = in_dma && gnt_raw;
    assign beat_clr   = !in_dma;
    assign burst_done = beat_inc && (beat_last || beat_sat);

    arb_age_counter #(
        .W   (CNT_W),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .sat_o  (wait_sat),
        .last_o (wait_last)
    );

    arb_age_counter #(
        .W   (CNT_W),
        .MAX (BURST_MAX)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (beat_clr),
        .inc_i  (beat_inc),
        .sat_o  (beat_sat),
        .last_o (beat_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                if (to_dma) begin
                    state_d = S_DMA;
                end
            end
            S_DMA: begin
                if (!dma_req || burst_done) begin
                    state_d = S_YIELD;
                end
            end
            S_YIELD: begin
                state_d = S_CPU;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CPU;
            stall_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_raw;
            rvalid_q <= gnt_read;
            if (gnt_read) begin
                rdata_q <= m_data_rdata;
            end
        end
    end

    // Reset also forces the combinational outputs low so nothing reaches memory while held.
    always_comb begin
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = BYTEEN_NONE;
        if (reset) begin
            if (gnt_raw) begin
                m_data_addr   = dma_addr;
                m_data_wdata  = dma_wdata;
                m_data_byteen = dma_byteen;
            end else if (!in_dma && cpu_req) begin
                m_data_addr   = cpu_addr;
                m_data_wdata  = cpu_wdata;
                m_data_byteen = cpu_byteen;
            end
        end
    end

    assign cpu_rdata  = (reset && !in_dma && !gnt_raw) ? m_data_rdata : '0;
    assign cpu_stall  = reset && stall_raw;
    assign dma_gnt    = reset && gnt_raw;
    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

endmodule
